// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory writer. Accepts a byte stream
//               over a valid/ready handshake, packs bytes into 32-bit words,
//               writes them at sequential word addresses starting from 0,
//               verifies a trailing XOR checksum byte and holds the processor
//               in reset until a load completes cleanly.
//
// Ports:
//   i_clk_w          clock, rising edge
//   i_rst_w          synchronous active-high reset
//   i_start_w        one-cycle pulse beginning a load session
//   i_word_count_w   number of words to load, sampled on i_start_w
//   i_byte_valid_w   stream byte valid
//   i_byte_w         stream byte
//   o_byte_ready_w   loader can accept a byte
//   o_we_w           instruction-memory write enable (one-cycle pulse)
//   o_waddr_w        word address of the write
//   o_wdata_w        word to write
//   o_cpu_rst_w      processor reset hold
//   o_busy_w         load in progress
//   o_done_w         last load succeeded (sticky until next start)
//   o_err_w          last load failed (sticky until next start)
//
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W     = 6,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 1024
) (
    input  logic              i_clk_w,
    input  logic              i_rst_w,
    input  logic              i_start_w,
    input  logic [ADDR_W:0]   i_word_count_w,
    input  logic              i_byte_valid_w,
    input  logic [7:0]        i_byte_w,
    output logic              o_byte_ready_w,
    output logic              o_we_w,
    output logic [ADDR_W-1:0] o_waddr_w,
    output logic [31:0]       o_wdata_w,
    output logic              o_cpu_rst_w,
    output logic              o_busy_w,
    output logic              o_done_w,
    output logic              o_err_w
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = ADDR_W + 1;
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);

    // Largest legal word count: exactly fills the memory.
    localparam logic [c_cnt_w-1:0] c_max_words = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [c_tmo_w-1:0] c_timeout   = c_tmo_w'(TIMEOUT);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CSUM  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_count;     // words requested for this session
    logic [c_cnt_w-1:0] r_word_cnt;  // words completed so far
    logic [1:0]         r_byte_idx;  // position of next byte inside the word
    logic [7:0]         r_csum;      // running XOR of all data bytes
    logic [c_tmo_w-1:0] r_tmo;       // idle cycles since the last accepted byte
    logic [31:0]        r_shift;     // word assembly register
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [31:0]        r_wdata;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_ready;
    logic               w_accept;
    logic               w_can_start;
    logic               w_count_bad;
    logic               w_last_byte;
    logic               w_last_word;
    logic               w_tmo_hit;
    logic [c_cnt_w-1:0] w_word_cnt_inc;
    logic [c_tmo_w-1:0] w_tmo_inc;
    logic [31:0]        w_word_next;

    assign w_ready        = (r_state == S_LOAD) || (r_state == S_CSUM);
    assign w_accept       = i_byte_valid_w && w_ready;
    assign w_can_start    = i_start_w &&
                            ((r_state == S_IDLE) || (r_state == S_DONE) ||
                             (r_state == S_ERROR));
    assign w_count_bad    = (i_word_count_w == '0) ||
                            (i_word_count_w > c_max_words);
    assign w_last_byte    = (r_byte_idx == 2'd3);
    assign w_word_cnt_inc = r_word_cnt + c_cnt_w'(1);
    assign w_last_word    = (w_word_cnt_inc == r_count);
    assign w_tmo_inc      = r_tmo + c_tmo_w'(1);
    // Fires on the idle cycle that would bring the counter up to TIMEOUT.
    assign w_tmo_hit      = !w_accept && (w_tmo_inc == c_timeout);

    // Byte placement: big-endian shifts new bytes in at the bottom so the
    // first byte ends up in [31:24]; little-endian shifts in at the top so the
    // first byte ends up in [7:0].
    generate
        if (BIG_ENDIAN) begin : g_big_endian
            assign w_word_next = {r_shift[23:0], i_byte_w};
        end else begin : g_little_endian
            assign w_word_next = {i_byte_w, r_shift[31:8]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start_w) begin
                    w_state_nxt = w_count_bad ? S_ERROR : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_last_byte && w_last_word) begin
                        w_state_nxt = S_CSUM;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = (i_byte_w == r_csum) ? S_DONE : S_ERROR;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: word assembly, checksum, counters and the write port
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            r_count    <= '0;
            r_word_cnt <= '0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'h00;
            r_tmo      <= '0;
            r_shift    <= 32'h0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= 32'h0;
        end else begin
            // Write enable is a single-cycle pulse.
            r_we <= 1'b0;

            if (w_can_start) begin
                r_count    <= i_word_count_w;
                r_word_cnt <= '0;
                r_byte_idx <= 2'd0;
                r_csum     <= 8'h00;
                r_tmo      <= '0;
                r_shift    <= 32'h0;
            end else if (w_ready) begin
                if (w_accept) begin
                    r_tmo <= '0;
                    // The checksum byte itself is only compared, never folded
                    // into the running XOR or the word register.
                    if (r_state == S_LOAD) begin
                        r_csum     <= r_csum ^ i_byte_w;
                        r_shift    <= w_word_next;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            r_we       <= 1'b1;
                            r_wdata    <= w_word_next;
                            r_waddr    <= r_word_cnt[ADDR_W-1:0];
                            r_word_cnt <= w_word_cnt_inc;
                        end
                    end
                end else begin
                    r_tmo <= w_tmo_inc;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Status flags derive directly from the state so they are sticky until the
    // next accepted start and return to reset values with the state register.
    assign o_byte_ready_w = w_ready;
    assign o_we_w         = r_we;
    assign o_waddr_w      = r_waddr;
    assign o_wdata_w      = r_wdata;
    assign o_busy_w       = w_ready;
    assign o_done_w       = (r_state == S_DONE);
    assign o_err_w        = (r_state == S_ERROR);
    assign o_cpu_rst_w    = (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. A big-endian instance
//               (TIMEOUT=16) and a little-endian instance share the stream
//               inputs; expected writes are queued when the 4th byte of a
//               word is driven and compared when o_we_w pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_be;
    logic              start_le;
    logic [ADDR_W:0]   word_count;
    logic              byte_valid;
    logic [7:0]        byte_d;

    logic              be_ready, be_we, be_cpu_rst, be_busy, be_done, be_err;
    logic [ADDR_W-1:0] be_waddr;
    logic [31:0]       be_wdata;
    logic              le_ready, le_we, le_cpu_rst, le_busy, le_done, le_err;
    logic [ADDR_W-1:0] le_waddr;
    logic [31:0]       le_wdata;

    int checks = 0;
    int errors = 0;
    int be_writes = 0;
    int le_writes = 0;

    logic [ADDR_W+31:0] exp_be[$];
    logic [ADDR_W+31:0] exp_le[$];
    logic [ADDR_W+31:0] mon_be_e;
    logic [ADDR_W+31:0] mon_le_e;
    logic [7:0]         stream[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1), .TIMEOUT(16)) dut_be (
        .i_clk_w(clk), .i_rst_w(rst), .i_start_w(start_be),
        .i_word_count_w(word_count), .i_byte_valid_w(byte_valid),
        .i_byte_w(byte_d), .o_byte_ready_w(be_ready), .o_we_w(be_we),
        .o_waddr_w(be_waddr), .o_wdata_w(be_wdata), .o_cpu_rst_w(be_cpu_rst),
        .o_busy_w(be_busy), .o_done_w(be_done), .o_err_w(be_err)
    );

    imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0), .TIMEOUT(1024)) dut_le (
        .i_clk_w(clk), .i_rst_w(rst), .i_start_w(start_le),
        .i_word_count_w(word_count), .i_byte_valid_w(byte_valid),
        .i_byte_w(byte_d), .o_byte_ready_w(le_ready), .o_we_w(le_we),
        .o_waddr_w(le_waddr), .o_wdata_w(le_wdata), .o_cpu_rst_w(le_cpu_rst),
        .o_busy_w(le_busy), .o_done_w(le_done), .o_err_w(le_err)
    );

    // Write monitors: every pulse must match the head of its scoreboard.
    always @(negedge clk) begin
        if (be_we) begin
            be_writes++;
            checks++;
            if (exp_be.size() == 0) begin
                errors++;
                $display("FAIL be_write_unexpected: got addr %0d data %h, required no write", be_waddr, be_wdata);
            end else begin
                mon_be_e = exp_be.pop_front();
                if ({be_waddr, be_wdata} !== mon_be_e) begin
                    errors++;
                    $display("FAIL be_write: got addr %0d data %h, required addr %0d data %h",
                             be_waddr, be_wdata, mon_be_e[ADDR_W+31:32], mon_be_e[31:0]);
                end
            end
        end
        if (le_we) begin
            le_writes++;
            checks++;
            if (exp_le.size() == 0) begin
                errors++;
                $display("FAIL le_write_unexpected: got addr %0d data %h, required no write", le_waddr, le_wdata);
            end else begin
                mon_le_e = exp_le.pop_front();
                if ({le_waddr, le_wdata} !== mon_le_e) begin
                    errors++;
                    $display("FAIL le_write: got addr %0d data %h, required addr %0d data %h",
                             le_waddr, le_wdata, mon_le_e[ADDR_W+31:32], mon_le_e[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // Drive one byte after 'gap' idle cycles; returns on the negedge after
    // the posedge that accepted it.
    task automatic send_byte(input bit le, input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_d     = b;
        n = 0;
        while (!(le ? le_ready : be_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_wait: ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Send the bytes in 'stream'; bytes of the first nwords words also push
    // the expected word into the matching scoreboard.
    task automatic send_stream(input bit le, input int nwords, input int max_gap);
        logic [31:0] w;
        for (int i = 0; i < stream.size(); i++) begin
            if (i < nwords * 4 && (i % 4) == 3) begin
                if (le) begin
                    w = {stream[i], stream[i-1], stream[i-2], stream[i-3]};
                    exp_le.push_back({6'(i / 4), w});
                end else begin
                    w = {stream[i-3], stream[i-2], stream[i-1], stream[i]};
                    exp_be.push_back({6'(i / 4), w});
                end
            end
            send_byte(le, stream[i], $urandom_range(0, max_gap));
        end
    endtask

    task automatic pulse_start(input bit le, input logic [ADDR_W:0] cnt);
        word_count = cnt;
        if (le) start_le = 1'b1;
        else    start_be = 1'b1;
        @(negedge clk);
        start_le = 1'b0;
        start_be = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({be_ready, be_we, be_busy, be_done, be_err, be_cpu_rst} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_be_flags: got %b, required 000001",
                     {be_ready, be_we, be_busy, be_done, be_err, be_cpu_rst});
        end
        checks++;
        if (be_waddr !== '0 || be_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_be_write_port: got addr %0d data %h, required 0 0", be_waddr, be_wdata);
        end
        checks++;
        if ({le_ready, le_we, le_busy, le_done, le_err, le_cpu_rst} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_le_flags: got %b, required 000001",
                     {le_ready, le_we, le_busy, le_done, le_err, le_cpu_rst});
        end
        checks++;
        if (le_waddr !== '0 || le_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_le_write_port: got addr %0d data %h, required 0 0", le_waddr, le_wdata);
        end
    endtask

    task automatic test_clean_load;
        int w0;
        w0 = be_writes;
        pulse_start(1'b0, 7'd2);
        checks++;
        if (be_busy !== 1'b1 || be_cpu_rst !== 1'b1 || be_ready !== 1'b1) begin
            errors++;
            $display("FAIL clean_start: got busy %b cpu_rst %b ready %b, required 1 1 1", be_busy, be_cpu_rst, be_ready);
        end
        stream = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
        send_stream(1'b0, 2, 0);
        checks++;
        if (be_cpu_rst !== 1'b1 || be_done !== 1'b0) begin
            errors++;
            $display("FAIL clean_before_csum: got cpu_rst %b done %b, required 1 0", be_cpu_rst, be_done);
        end
        send_byte(1'b0, 8'h08, 0);
        checks++;
        if ({be_done, be_err, be_cpu_rst, be_busy, be_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL clean_done: got done/err/cpu_rst/busy/ready %b, required 10000",
                     {be_done, be_err, be_cpu_rst, be_busy, be_ready});
        end
        @(negedge clk); #1;
        checks++;
        if (be_writes - w0 !== 2) begin
            errors++;
            $display("FAIL clean_write_count: got %0d, required 2", be_writes - w0);
        end
    endtask

    task automatic test_bad_count_restart;
        int w0;
        w0 = be_writes;
        pulse_start(1'b0, 7'd0);
        checks++;
        if (be_err !== 1'b1 || be_done !== 1'b0 || be_cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL count0_err: got err %b done %b cpu_rst %b, required 1 0 1", be_err, be_done, be_cpu_rst);
        end
        pulse_start(1'b0, 7'd64);
        checks++;
        if (be_err !== 1'b0 || be_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_error: got err %b busy %b, required 0 1", be_err, be_busy);
        end
        stream = {};
        for (int i = 0; i < 256; i++) stream.push_back(8'h00);
        send_stream(1'b0, 64, 0);
        send_byte(1'b0, 8'h00, 0);
        checks++;
        if (be_done !== 1'b1 || be_err !== 1'b0) begin
            errors++;
            $display("FAIL full_done: got done %b err %b, required 1 0", be_done, be_err);
        end
        @(negedge clk); #1;
        checks++;
        if (be_writes - w0 !== 64) begin
            errors++;
            $display("FAIL full_write_count: got %0d, required 64", be_writes - w0);
        end
        pulse_start(1'b0, 7'd65);
        checks++;
        if (be_err !== 1'b1 || be_done !== 1'b0) begin
            errors++;
            $display("FAIL count65_err: got err %b done %b, required 1 0", be_err, be_done);
        end
    endtask

    task automatic test_bad_checksum;
        int w0;
        w0 = be_writes;
        pulse_start(1'b0, 7'd2);
        stream = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
        send_stream(1'b0, 2, 0);
        send_byte(1'b0, 8'h09, 0);
        checks++;
        if ({be_done, be_err, be_cpu_rst, be_busy} !== 4'b0110) begin
            errors++;
            $display("FAIL badcsum_flags: got done/err/cpu_rst/busy %b, required 0110",
                     {be_done, be_err, be_cpu_rst, be_busy});
        end
        @(negedge clk); #1;
        checks++;
        if (be_writes - w0 !== 2) begin
            errors++;
            $display("FAIL badcsum_write_count: got %0d, required 2", be_writes - w0);
        end
    endtask

    task automatic test_le_backpressure;
        int w0;
        w0 = le_writes;
        pulse_start(1'b1, 7'd1);
        stream = '{8'h05, 8'h00, 8'h02, 8'h20};
        send_stream(1'b1, 1, 3);
        send_byte(1'b1, 8'h27, $urandom_range(0, 3));
        checks++;
        if (le_done !== 1'b1 || le_err !== 1'b0 || le_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL le_done: got done %b err %b cpu_rst %b, required 1 0 0", le_done, le_err, le_cpu_rst);
        end
        @(negedge clk); #1;
        checks++;
        if (le_writes - w0 !== 1) begin
            errors++;
            $display("FAIL le_write_count: got %0d, required 1", le_writes - w0);
        end
    endtask

    task automatic test_timeout;
        int w0;
        w0 = be_writes;
        pulse_start(1'b0, 7'd2);
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_stream(1'b0, 2, 0);
        repeat (15) @(negedge clk);
        checks++;
        if (be_err !== 1'b0 || be_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got err %b busy %b after 15 idle, required 0 1", be_err, be_busy);
        end
        @(negedge clk);
        checks++;
        if (be_err !== 1'b1 || be_ready !== 1'b0 || be_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: got err %b ready %b busy %b, required 1 0 0", be_err, be_ready, be_busy);
        end
        @(negedge clk); #1;
        checks++;
        if (be_writes - w0 !== 1) begin
            errors++;
            $display("FAIL timeout_write_count: got %0d, required 1", be_writes - w0);
        end
    endtask

    task automatic test_reset_midload;
        int w0;
        w0 = be_writes;
        pulse_start(1'b0, 7'd2);
        stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03};
        send_stream(1'b0, 2, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({be_ready, be_we, be_busy, be_done, be_err, be_cpu_rst} !== 6'b000001 ||
            be_waddr !== '0 || be_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midload_reset: got flags %b addr %0d data %h, required 000001 0 0",
                     {be_ready, be_we, be_busy, be_done, be_err, be_cpu_rst}, be_waddr, be_wdata);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (be_writes - w0 !== 1) begin
            errors++;
            $display("FAIL midload_write_count: got %0d, required 1", be_writes - w0);
        end
        pulse_start(1'b0, 7'd2);
        stream = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
        send_stream(1'b0, 2, 0);
        send_byte(1'b0, 8'h08, 0);
        checks++;
        if (be_done !== 1'b1 || be_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_load: got done %b cpu_rst %b, required 1 0", be_done, be_cpu_rst);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start_be   = 1'b0;
        start_le   = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_d     = 8'h00;

        test_reset();
        test_clean_load();
        test_bad_count_restart();
        test_bad_checksum();
        test_le_backpressure();
        test_timeout();
        test_reset_midload();

        repeat (2) @(negedge clk); #1;
        checks++;
        if (exp_be.size() != 0 || exp_le.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending writes, required 0/0", exp_be.size(), exp_le.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit words and issues one write per word at sequential word addresses from 0.
- It verifies a trailing XOR checksum byte.
- It holds the processor in reset until a load completes cleanly.
- It sits between the top level's external load port and the instruction memory's write side.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (2**ADDR_W words).
- BIG_ENDIAN, 1, 1: first byte of a word goes to [31:24]; 0: first byte goes to [7:0].
- TIMEOUT, 1024, maximum idle cycles between bytes during a load before error; minimum 2.

Ports:
- i_clk_w  in  1  clock, rising edge.
- i_rst_w  in  1  synchronous, active-high reset.
- i_start_w  in  1  one-cycle pulse that begins a load session.
- i_word_count_w  in  ADDR_W+1  number of words to load; sampled on i_start_w.
- i_byte_valid_w  in  1  stream byte valid.
- i_byte_w  in  8  stream byte.
- o_byte_ready_w  out  1  loader can accept a byte.
- o_we_w  out  1  instruction-memory write enable, one-cycle pulse.
- o_waddr_w  out  ADDR_W  word address of the write.
- o_wdata_w  out  32  word to write.
- o_cpu_rst_w  out  1  processor reset hold.
- o_busy_w  out  1  load in progress.
- o_done_w  out  1  last load succeeded; sticky.
- o_err_w  out  1  last load failed; sticky.

Behaviour:
- Reset values:
  - State IDLE.
  - o_byte_ready_w=0, o_we_w=0, o_waddr_w=0, o_wdata_w=0.
  - o_cpu_rst_w=1, o_busy_w=0, o_done_w=0, o_err_w=0.
  - Internal byte index, word counter, checksum and timeout counter are all 0.
- Byte transfer: a byte is accepted in any cycle with i_byte_valid_w && o_byte_ready_w. The byte is discarded if not accepted.
- State IDLE:
  - o_byte_ready_w=0.
  - On i_start_w: latch the count and clear o_done_w, o_err_w, the checksum and the counters; set o_cpu_rst_w=1.
  - If the count is 0 or greater than 2**ADDR_W, go to ERROR. Otherwise go to LOAD with o_busy_w=1.
- State LOAD:
  - o_byte_ready_w=1.
  - Each accepted byte is XORed into the checksum and placed in the word shift register per BIG_ENDIAN. Byte index wraps 3 -> 0.
  - On acceptance of byte index 3:
    - In the next cycle, o_we_w=1, o_wdata_w = the completed word, and o_waddr_w = the word counter value before increment.
    - The word counter then increments.
  - After the last word's 4th byte, go to CSUM.
  - Acceptance continues in the same cycle a write pulse is presented; no bubble is required.
- State CSUM:
  - o_byte_ready_w=1.
  - The next accepted byte is compared to the running XOR.
  - Equal: go to DONE.
  - Not equal: go to ERROR.
- State DONE: o_done_w=1, o_busy_w=0, o_cpu_rst_w=0, o_byte_ready_w=0.
- State ERROR: o_err_w=1, o_busy_w=0, o_cpu_rst_w=1, o_byte_ready_w=0.
  - Words already written remain in memory. There is no rollback.
- Leaving DONE or ERROR: i_start_w restarts a load exactly as from IDLE; o_cpu_rst_w reasserts in the cycle after the start pulse.
- Timeout:
  - In LOAD and CSUM, the counter increments every cycle without an accepted byte and clears on acceptance.
  - Reaching TIMEOUT goes to ERROR. The final write pulse of a completed word is still issued if it is pending.
- Start during a load: i_start_w in LOAD or CSUM is ignored.
- Address width: o_waddr_w never exceeds 2**ADDR_W-1. A count of exactly 2**ADDR_W fills the memory and writes address 2**ADDR_W-1 last.
- Reset mid-load: immediately returns every output to its reset value. A pending write pulse is suppressed.
- Latency:
  - o_we_w is asserted 1 cycle after the 4th byte of a word is accepted.
  - o_done_w or o_err_w is asserted 1 cycle after the checksum byte is accepted.

Test Plan:
- Clean load: reset; start with count=2; bytes 20 02 00 05 20 03 00 0C 08 sent back-to-back -> o_we_w pulses with addr0=0x20020005 and addr1=0x2003000C; o_done_w=1; o_cpu_rst_w falls 1 cycle after the checksum byte; o_err_w=0.
- Bad checksum: same stream with final byte 09 -> both writes occur; o_err_w=1; o_done_w=0; o_cpu_rst_w stays 1.
- Little-endian and backpressure: BIG_ENDIAN=0; count=1; bytes 05 00 02 20 with valid gaps of 0–3 cycles; checksum 27 -> addr0=0x20020005; o_done_w=1.
- Bad count and restart: count=0 -> o_err_w=1 in the next cycle with no writes. Then start with count=64 and 64 words of 0x00000000 plus checksum 00 -> 64 writes at addresses 0..63; o_done_w=1.
- Timeout: TIMEOUT=16; send 6 bytes then stall 16 cycles -> exactly one write at addr0; o_err_w=1; o_byte_ready_w=0.
- Reset mid-load: assert i_rst_w after 3 bytes of word 1 -> next cycle all outputs at reset values and no write pulse; a subsequent clean load succeeds.
